// File: rtl/decode_stage.sv
// Decode stage: one-deep output register with ready/valid handshake, immediate
// generation and a register file with write-back bypass on the read path.
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int RF_INIT = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] rf_q [NREGS];
  logic [AW-1:0]   rs1_a, rs2_a, wb_a;
  logic            accept;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q, imm_q, rs1_data_q, rs2_data_q;
  logic            illegal_q;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_d;
  logic [31:0]     imm32;
  logic            illegal_d;

  assign rs1_a = in_instr[15 +: AW];
  assign rs2_a = in_instr[20 +: AW];
  assign wb_a  = wb_rd[AW-1:0];

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  // Operands see a write-back landing on the same edge as the accept.
  always_comb begin
    rs1_val = rf_q[rs1_a];
    rs2_val = rf_q[rs2_a];
    if (wb_en && wb_a == rs1_a) rs1_val = wb_data;
    if (wb_en && wb_a == rs2_a) rs2_val = wb_data;
    if (rs1_a == '0) rs1_val = '0;
    if (rs2_a == '0) rs2_val = '0;
  end

  always_comb begin
    imm32     = '0;
    illegal_d = 1'b0;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      7'b0100011:
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      7'b1100011:
        imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {in_instr[31:12], 12'b0};
      7'b1101111:
        imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      7'b0110011:
        imm32 = '0;
      default:
        illegal_d = 1'b1;
    endcase
  end

  // 32-bit immediate is already sign-extended; widen keeping the sign.
  assign imm_d = XLEN'($signed(imm32));

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      illegal_q  <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        instr_q    <= in_instr;
        pc_q       <= in_pc;
        imm_q      <= imm_d;
        illegal_q  <= illegal_d;
        rs1_data_q <= rs1_val;
        rs2_data_q <= rs2_val;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        rf_q[i] <= (RF_INIT == 1) ? XLEN'(i) : '0;
    end else if (wb_en && wb_a != '0) begin
      rf_q[wb_a] <= wb_data;
    end
  end

  assign out_valid    = valid_q;
  assign out_rs1_data = rs1_data_q;
  assign out_rs2_data = rs2_data_q;
  assign out_imm      = imm_q;
  assign out_rs1      = instr_q[19:15];
  assign out_rs2      = instr_q[24:20];
  assign out_rd       = instr_q[11:7];
  assign out_opcode   = instr_q[6:0];
  assign out_funct3   = instr_q[14:12];
  assign out_funct7   = instr_q[31:25];
  assign out_pc       = pc_q;
  assign out_illegal  = illegal_q;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- NREGS, 32, register count; a power of two, at most 32.
- RF_INIT, 1, register file reset pattern: 0 = all zero, 1 = reg[i] = i.
REQ-002 SHALL define AW = log2(NREGS) as the register address width.
REQ-003 SHALL have one clock; reset is synchronous and active-high. Ports are named clock and reset.
REQ-004 SHALL have ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard the output stage and the current acceptance
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts the bundle
- out_rs1_data, out_rs2_data  out  XLEN  operand values
- out_imm  out  XLEN  sign-extended immediate
- out_rs1, out_rs2, out_rd  out  5  register fields
- out_opcode  out  7  opcode field
- out_funct3  out  3  funct3 field
- out_funct7  out  7  funct7 field
- out_pc  out  XLEN  registered in_pc
- out_illegal  out  1  unsupported opcode
- wb_en  in  1  write-back strobe
- wb_rd  in  5  write-back destination
- wb_data  in  XLEN  write-back value

Function
REQ-005 SHALL use in_ready = !out_valid || out_ready, combinationally.
REQ-006 SHALL accept an instruction when in_valid && in_ready && !flush. Every out_* field updates on the next edge, giving 1-cycle latency.
REQ-007 SHALL set out_valid on the edge after an accept. It SHALL clear out_valid on an edge where out_ready is 1 and no accept occurs.
REQ-008 SHALL hold all out_* values unchanged while out_valid && !out_ready (stall).
REQ-009 SHALL clear out_valid on any edge where flush is 1. flush SHALL NOT affect register file writes.
REQ-010 SHALL write wb_data to reg[wb_rd] at the edge when wb_en = 1 and wb_rd != 0. Only the low AW bits of wb_rd are used.
REQ-011 SHALL treat reg[0] as constant zero: writes to it are ignored and reads of it return 0.
REQ-012 SHALL bypass write-back on an accept: if wb_en = 1, wb_rd == rsN, and rsN != 0, out_rsN_data is wb_data rather than the stored value.
REQ-013 SHALL take operand values at the accept edge only. A later write-back to the same register does not alter a stalled bundle.
REQ-014 SHALL build immediates as follows, each sign-extended from instr[31] to XLEN:
- I for opcodes 0010011, 0000011, 1100111: instr[31:20].
- S for 0100011: {instr[31:25], instr[11:7]}.
- B for 1100011: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- U for 0110111, 0010111: {instr[31:12], 12'b0}.
- J for 1101111: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-015 SHALL set imm = 0 for 0110011 (R-type).
REQ-016 SHALL set out_illegal = 1 and imm = 0 for any other opcode. out_illegal SHALL be 0 for all opcodes in REQ-014 and REQ-015.
REQ-017 SHALL pass field outputs through unmodified from in_instr, including for illegal opcodes.

Reset
REQ-018 SHALL give reset precedence over flush, accept and write-back.
REQ-019 SHALL, during reset, force out_valid = 0 and every other out_* register to 0.
REQ-020 SHALL, during reset, load reg[i] = 0 when RF_INIT = 0 and reg[i] = i when RF_INIT = 1, with reg[0] = 0 in both cases.
REQ-021 SHALL drive in_ready = 1 on the first cycle after reset deasserts.

Verification
REQ-022 Reset with RF_INIT=1, then accept 0x00208033 (add x0,x1,x2) -> next cycle out_valid=1, rs1_data=1, rs2_data=2, illegal=0, imm=0.
REQ-023 Accept 0xFFF00093 (addi x1,x0,-1) with XLEN=64 -> imm=0xFFFFFFFFFFFFFFFF, rd=1, rs1_data=0.
REQ-024 wb_en=1, wb_rd=5, wb_data=0xDEADBEEF on the same edge as accepting an instruction with rs1=5 -> rs1_data=0xDEADBEEF; a later read of x5 also returns 0xDEADBEEF.
REQ-025 out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 and outputs unchanged; a write-back to that bundle's rs1 during the stall leaves rs1_data unchanged; out_ready=1 -> next instruction appears 1 cycle later.
REQ-026 Accept 0xFE000EE3 (B-type, offset -4) -> imm=0xFFFFFFFC; accept 0x0000007F -> illegal=1, imm=0.
REQ-027 Assert flush and reset together while out_valid=1 -> out_valid=0 and the register file is restored to its init pattern.
